// File: rtl/dtc_vote_pkg.sv
// dtc_vote_pkg
// Shared definitions for the decision-tree vote accumulator: the number of
// classes a tree can vote for, the width of a class code, and the controller
// state encoding. No ports; imported by dtc_vote_accum.

package dtc_vote_pkg;

  localparam int NUM_CLASSES = 8;
  localparam int CLASS_W     = 3;

  // ACCUM collects votes, SCAN walks the counters one class per cycle,
  // HOLD presents the decision until downstream takes it.
  typedef enum logic [1:0] {
    ST_ACCUM = 2'd0,
    ST_SCAN  = 2'd1,
    ST_HOLD  = 2'd2
  } state_e;

endpackage : dtc_vote_pkg

// File: rtl/dtc_vote_accum.sv
// dtc_vote_accum
// Majority-vote accumulator that sits behind a tree classifier. Class votes
// are counted into one counter per class; when WINDOW votes have arrived (or
// flush requests an early decision on a non-empty window) the counters are
// scanned sequentially, lowest class first, and the class with the strictly
// largest count is presented downstream with its vote count.
//
// Ports
//   clk        : single clock, all state changes on its rising edge
//   rst        : synchronous active-high reset
//   in_valid   : a class vote is present
//   in_class   : class code of that vote
//   in_ready   : vote accepted this cycle (high only while accumulating)
//   flush      : decide early on the partial window
//   out_valid  : a decision is presented (high only while holding)
//   out_class  : winning class
//   out_votes  : vote count of the winning class
//   out_ready  : downstream accepts the decision

module dtc_vote_accum
  import dtc_vote_pkg::*;
#(
  parameter  int WINDOW = 16,
  localparam int CNT_W  = $clog2(WINDOW + 1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  input  logic [CLASS_W-1:0] in_class,
  output logic               in_ready,
  input  logic               flush,
  output logic               out_valid,
  output logic [CLASS_W-1:0] out_class,
  output logic [CNT_W-1:0]   out_votes,
  input  logic               out_ready
);

  // Sample-counter value just before the vote that completes the window.
  localparam logic [CNT_W-1:0]   LAST_VOTE  = CNT_W'(WINDOW - 1);
  localparam logic [CLASS_W-1:0] LAST_CLASS = CLASS_W'(NUM_CLASSES - 1);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   count_q [NUM_CLASSES];
  logic [CNT_W-1:0]   count_d [NUM_CLASSES];
  logic [CNT_W-1:0]   sample_q, sample_d;
  logic [CLASS_W-1:0] idx_q, idx_d;
  logic [CLASS_W-1:0] best_class_q, best_class_d;
  logic [CNT_W-1:0]   best_votes_q, best_votes_d;
  logic               accept;
  logic               window_full;
  logic               flush_go;

  // Next-state and datapath logic. Everything holds by default; each state
  // only touches the registers it owns.
  always_comb begin
    state_d      = state_q;
    count_d      = count_q;
    sample_d     = sample_q;
    idx_d        = idx_q;
    best_class_d = best_class_q;
    best_votes_d = best_votes_q;
    in_ready     = 1'b0;
    out_valid    = 1'b0;
    accept       = 1'b0;
    window_full  = 1'b0;
    flush_go     = 1'b0;

    unique case (state_q)
      ST_ACCUM: begin
        in_ready = 1'b1;
        accept   = in_valid;
        if (accept) begin
          count_d[in_class] = count_q[in_class] + CNT_W'(1);
          sample_d          = sample_q + CNT_W'(1);
        end
        window_full = accept && (sample_q == LAST_VOTE);
        // A vote arriving alongside flush is counted first, so the window
        // is non-empty even if it was empty before this cycle.
        flush_go    = flush && ((sample_q != '0) || accept);
        if (window_full || flush_go) begin
          state_d      = ST_SCAN;
          idx_d        = '0;
          best_class_d = '0;
          best_votes_d = '0;
        end
      end

      ST_SCAN: begin
        // Strict comparison keeps the earlier (lower) class on a tie.
        if (count_q[idx_q] > best_votes_q) begin
          best_class_d = idx_q;
          best_votes_d = count_q[idx_q];
        end
        if (idx_q == LAST_CLASS) begin
          state_d = ST_HOLD;
          idx_d   = '0;
        end else begin
          idx_d = idx_q + CLASS_W'(1);
        end
      end

      ST_HOLD: begin
        out_valid = 1'b1;
        if (out_ready) begin
          state_d  = ST_ACCUM;
          sample_d = '0;
          for (int i = 0; i < NUM_CLASSES; i++) begin
            count_d[i] = '0;
          end
        end
      end

      default: begin
        state_d = ST_ACCUM;
      end
    endcase
  end

  // State and datapath registers; reset discards any decision in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_ACCUM;
      sample_q     <= '0;
      idx_q        <= '0;
      best_class_q <= '0;
      best_votes_q <= '0;
      for (int i = 0; i < NUM_CLASSES; i++) begin
        count_q[i] <= '0;
      end
    end else begin
      state_q      <= state_d;
      sample_q     <= sample_d;
      idx_q        <= idx_d;
      best_class_q <= best_class_d;
      best_votes_q <= best_votes_d;
      count_q      <= count_d;
    end
  end

  assign out_class = best_class_q;
  assign out_votes = best_votes_q;

endmodule : dtc_vote_accum

// File: tb/tb_dtc_vote_accum.sv
// tb_dtc_vote_accum
// Scoreboarded bench for dtc_vote_accum with WINDOW=16. Stimulus pushes the
// hand-computed decision into a queue before driving the votes; a monitor
// pops and compares whenever a decision is handed off downstream.

module tb_dtc_vote_accum;

  localparam int WINDOW = 16;
  localparam int CNT_W  = $clog2(WINDOW + 1);

  typedef struct {
    int cls;
    int votes;
  } exp_t;

  logic             clk;
  logic             rst;
  logic             in_valid;
  logic [2:0]       in_class;
  logic             in_ready;
  logic             flush;
  logic             out_valid;
  logic [2:0]       out_class;
  logic [CNT_W-1:0] out_votes;
  logic             out_ready;

  exp_t sbQ[$];
  int   vecCount  = 0;
  int   missCount = 0;

  dtc_vote_accum #(.WINDOW(WINDOW)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_class  (in_class),
    .in_ready  (in_ready),
    .flush     (flush),
    .out_valid (out_valid),
    .out_class (out_class),
    .out_votes (out_votes),
    .out_ready (out_ready)
  );

  // 10 ns clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point: bumps the counters and reports a miss.
  task automatic checkOutput(input string name, input int actual, input int expected);
    vecCount++;
    if (actual != expected) begin
      missCount++;
      $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
    end
  endtask

  // Drives one cycle of inputs; entered and left at posedge+1.
  task automatic applyStimulus(input logic v, input logic [2:0] c, input logic f);
    in_valid = v;
    in_class = c;
    flush    = f;
    @(posedge clk); #1;
    in_valid = 1'b0;
    flush    = 1'b0;
  endtask

  task automatic pushExpected(input int cls, input int votes);
    exp_t e;
    e.cls   = cls;
    e.votes = votes;
    sbQ.push_back(e);
  endtask

  // Waits (bounded) for a decision, then lets the handoff edge pass.
  task automatic waitDecision(input string name);
    int n = 0;
    while (!out_valid && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    if (!out_valid) begin
      checkOutput({name, "_timeout"}, 0, 1);
    end else begin
      @(posedge clk); #1;
    end
  endtask

  // Monitor: compares each decision taken by downstream against the queue.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst && out_valid && out_ready) begin
        if (sbQ.size() == 0) begin
          checkOutput("unexpectedDecision", 1, 0);
        end else begin
          e = sbQ.pop_front();
          checkOutput("decisionClass", int'(out_class), e.cls);
          checkOutput("decisionVotes", int'(out_votes), e.votes);
        end
      end
    end
  end

  initial begin
    int cnt[8];
    int nVotes, bestC, bestV, c;

    rst       = 1'b1;
    in_valid  = 1'b0;
    in_class  = 3'd0;
    flush     = 1'b0;
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    // Reset state
    checkOutput("rstInReady", int'(in_ready), 1);
    checkOutput("rstOutValid", int'(out_valid), 0);
    checkOutput("rstOutClass", int'(out_class), 0);
    checkOutput("rstOutVotes", int'(out_votes), 0);

    // 16 back-to-back class-5 votes, with cycle-exact latency
    pushExpected(5, 16);
    for (int i = 0; i < 16; i++) applyStimulus(1'b1, 3'd5, 1'b0);
    checkOutput("fullInReadyT1", int'(in_ready), 0);
    for (int k = 1; k <= 8; k++) begin
      checkOutput("fullScanNoValid", int'(out_valid), 0);
      @(posedge clk); #1;
    end
    checkOutput("fullValidT9", int'(out_valid), 1);
    checkOutput("fullInReadyT9", int'(in_ready), 0);
    @(posedge clk); #1;
    checkOutput("fullBackToAccum", int'(in_ready), 1);

    // Tie between classes 2 and 6 goes to class 2
    pushExpected(2, 6);
    for (int i = 0; i < 6; i++) applyStimulus(1'b1, 3'd2, 1'b0);
    for (int i = 0; i < 6; i++) applyStimulus(1'b1, 3'd6, 1'b0);
    for (int i = 0; i < 4; i++) applyStimulus(1'b1, 3'd1, 1'b0);
    waitDecision("tie");
    checkOutput("tieBackToAccum", int'(in_ready), 1);

    // Flush on an empty window does nothing
    applyStimulus(1'b0, 3'd0, 1'b1);
    for (int k = 0; k < 3; k++) begin
      checkOutput("emptyFlushInReady", int'(in_ready), 1);
      checkOutput("emptyFlushOutValid", int'(out_valid), 0);
      @(posedge clk); #1;
    end

    // Three class-7 votes, then flush alone
    pushExpected(7, 3);
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 3'd7, 1'b0);
    applyStimulus(1'b0, 3'd0, 1'b1);
    checkOutput("flushInReadyT1", int'(in_ready), 0);
    for (int k = 1; k < 8; k++) begin
      @(posedge clk); #1;
    end
    checkOutput("flushValidT8", int'(out_valid), 0);
    @(posedge clk); #1;
    checkOutput("flushValidT9", int'(out_valid), 1);
    @(posedge clk); #1;

    // Flush together with a vote: the vote is counted first
    pushExpected(4, 3);
    applyStimulus(1'b1, 3'd4, 1'b0);
    applyStimulus(1'b1, 3'd4, 1'b0);
    applyStimulus(1'b1, 3'd4, 1'b1);
    waitDecision("flushWithVote");

    // Back-pressure: HOLD stays stable for 20 cycles, input ignored
    out_ready = 1'b0;
    pushExpected(1, 10);
    for (int i = 0; i < 6; i++) applyStimulus(1'b1, 3'd0, 1'b0);
    for (int i = 0; i < 10; i++) applyStimulus(1'b1, 3'd1, 1'b0);
    for (int k = 0; k < 20 && !out_valid; k++) begin
      @(posedge clk); #1;
    end
    for (int k = 0; k < 20; k++) begin
      checkOutput("holdOutValid", int'(out_valid), 1);
      checkOutput("holdOutClass", int'(out_class), 1);
      checkOutput("holdOutVotes", int'(out_votes), 10);
      checkOutput("holdInReady", int'(in_ready), 0);
      applyStimulus(k[0], 3'd3, 1'b1);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    checkOutput("releaseInReady", int'(in_ready), 1);
    checkOutput("releaseOutValid", int'(out_valid), 0);
    // A single class-6 vote must win, proving the old counts were cleared
    pushExpected(6, 1);
    applyStimulus(1'b1, 3'd6, 1'b1);
    waitDecision("clearedCounts");

    // Reset in the fourth SCAN cycle discards the decision
    for (int i = 0; i < 16; i++) applyStimulus(1'b1, 3'd2, 1'b0);
    repeat (3) begin
      @(posedge clk); #1;
    end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    checkOutput("midScanRstInReady", int'(in_ready), 1);
    checkOutput("midScanRstOutValid", int'(out_valid), 0);
    checkOutput("midScanRstOutVotes", int'(out_votes), 0);
    pushExpected(3, 16);
    for (int i = 0; i < 16; i++) applyStimulus(1'b1, 3'd3, 1'b0);
    waitDecision("afterRst");

    // Random windows with gaps, checked against a counting model
    for (int w = 0; w < 8; w++) begin
      for (int i = 0; i < 8; i++) cnt[i] = 0;
      nVotes = (w == 0) ? 16 : int'($urandom_range(1, 16));
      for (int v = 0; v < nVotes; v++) begin
        c = int'($urandom_range(0, 7));
        cnt[c]++;
        repeat ($urandom_range(0, 2)) applyStimulus(1'b0, 3'(c + 1), 1'b0);
        applyStimulus(1'b1, 3'(c), 1'b0);
      end
      bestC = 0;
      bestV = 0;
      for (int i = 0; i < 8; i++) begin
        if (cnt[i] > bestV) begin
          bestC = i;
          bestV = cnt[i];
        end
      end
      pushExpected(bestC, bestV);
      if (nVotes < 16) applyStimulus(1'b0, 3'd0, 1'b1);
      waitDecision("random");
    end

    repeat (3) @(posedge clk);
    #1;
    checkOutput("scoreboardDrained", sbQ.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
    $finish;
  end

endmodule : tb_dtc_vote_accum
